// File: rtl/if_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : if_fetch_unit_pkg
// Brief   : Shared CPU constants and types for the instruction-fetch front end
// Revision: 1.0 - initial release
// ============================================================================
package if_fetch_unit_pkg;

    // Instruction / address width of the core
    localparam int unsigned c_INST_W = 32;

    // First fetch address after reset (MIPS boot ROM vector)
    localparam logic [c_INST_W-1:0] c_RESET_PC = 32'hbfc0_0000;

    // One-cycle view of the sram-like instruction bus
    typedef struct packed {
        logic [c_INST_W-1:0] addr;
        logic [c_INST_W-1:0] data;
        logic                req;
        logic                addr_ok;
        logic                data_ok;
    } inst_bus_t;

    // Fetch control state: issuing requests, or draining wrong-path responses
    typedef enum logic [0:0] {
        FS_RUN    = 1'b0,
        FS_CANCEL = 1'b1
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/if_fetch_unit_queue.sv
`default_nettype none
// ============================================================================
// Module  : fetch_queue
// Brief   : In-order {pc, inst} FIFO with push/pop/flush; push and pop in the
//           same cycle are legal at any fill level
// Revision: 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [W-1:0]             i_push_pc,
    input  logic [W-1:0]             i_push_inst,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [W-1:0]             o_head_pc,
    output logic [W-1:0]             o_head_inst,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);

    localparam int unsigned c_AW = $clog2(DEPTH);
    localparam int unsigned c_CW = c_AW + 1;

    logic [2*W-1:0]  r_mem [DEPTH];
    logic [c_AW-1:0] r_head;
    logic [c_AW-1:0] r_tail;
    logic [c_CW-1:0] r_count;
    logic            w_do_pop;
    logic            w_do_push;

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == c_CW'(DEPTH));
    assign o_count  = r_count;
    assign w_do_pop = i_pop && !o_empty;
    // When full, a pop frees the head slot in the same edge the tail writes it
    assign w_do_push = i_push && (!o_full || w_do_pop);

    assign {o_head_pc, o_head_inst} = r_mem[r_head];

    // Entry storage: written at the tail, no reset needed
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_tail] <= {i_push_pc, i_push_inst};
        end
    end

    // Pointers and fill level; flush empties the queue outright
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_tail <= r_tail + 1'b1;
            if (w_do_pop)  r_head <= r_head + 1'b1;
            r_count <= r_count + c_CW'(w_do_push) - c_CW'(w_do_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : if_fetch_unit
// Brief   : Instruction-fetch front end: sequential PC generation, credit-based
//           requests on a variable-latency sram-like bus, in-order instruction
//           queue towards decode, and wrong-path cancellation on redirect
// Revision: 1.0 - initial release
// ============================================================================
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned     PC_W      = c_INST_W,
    parameter logic [PC_W-1:0] RESET_PC  = c_RESET_PC,
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            id_allowin,
    output logic            if_to_id_valid,
    output logic [PC_W-1:0] if_to_id_inst,
    output logic [PC_W-1:0] if_to_id_pc,
    output logic            inst_req,
    output logic [PC_W-1:0] inst_addr,
    input  logic            inst_addr_ok,
    input  logic            inst_data_ok,
    input  logic [PC_W-1:0] inst_rdata
);

    localparam int unsigned c_AW = $clog2(BUF_DEPTH);
    localparam int unsigned c_CW = c_AW + 1;

    fetch_state_e    r_state;
    fetch_state_e    w_state_next;
    logic [c_CW-1:0] r_cancel;
    logic [c_CW-1:0] w_cancel_next;
    logic [PC_W-1:0] r_fetch_pc;
    logic [c_CW-1:0] r_outstanding;
    logic [PC_W-1:0] r_pcf [BUF_DEPTH];
    logic [c_AW-1:0] r_pcf_wr;
    logic [c_AW-1:0] r_pcf_rd;
    inst_bus_t       w_bus;
    logic            w_credit;
    logic            w_req;
    logic            w_hs;
    logic            w_resp;
    logic            w_push;
    logic            w_pop;
    logic [c_CW-1:0] w_q_count;
    logic            w_q_empty;
    logic            w_q_full;

    // Every accepted request owns a queue slot, so the queue cannot overflow
    assign w_credit = ({1'b0, w_q_count} + {1'b0, r_outstanding}) < (c_CW+1)'(BUF_DEPTH);
    // Held low while reset is asserted so the request drops asynchronously
    assign w_req    = (r_state == FS_RUN) && w_credit && !reset;

    assign w_bus = '{addr:    r_fetch_pc,
                     data:    inst_rdata,
                     req:     w_req,
                     addr_ok: inst_addr_ok,
                     data_ok: inst_data_ok};

    assign inst_req  = w_bus.req;
    assign inst_addr = w_bus.addr;
    assign w_hs      = w_bus.req && w_bus.addr_ok;
    // Stray responses (nothing outstanding) are ignored
    assign w_resp    = (r_state == FS_RUN) && (r_cancel == '0) &&
                       w_bus.data_ok && (r_outstanding != '0);
    // A response arriving with a redirect belongs to the wrong path
    assign w_push    = w_resp && !br_taken;
    assign if_to_id_valid = !w_q_empty;
    assign w_pop     = if_to_id_valid && id_allowin;

    // State register and wrong-path response counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= FS_RUN;
            r_cancel <= '0;
        end else begin
            r_state  <= w_state_next;
            r_cancel <= w_cancel_next;
        end
    end

    // Next state: redirect converts in-flight fetches into drops; CANCEL drains them
    always_comb begin
        w_state_next  = r_state;
        w_cancel_next = r_cancel;
        case (r_state)
            FS_RUN: begin
                if (br_taken) begin
                    w_cancel_next = r_outstanding + c_CW'(w_hs) - c_CW'(w_resp);
                    if (w_cancel_next != '0) w_state_next = FS_CANCEL;
                end
            end
            FS_CANCEL: begin
                if (w_bus.data_ok && (r_cancel != '0)) w_cancel_next = r_cancel - 1'b1;
                if (w_cancel_next == '0) w_state_next = FS_RUN;
            end
            default: begin
                w_state_next  = FS_RUN;
                w_cancel_next = '0;
            end
        endcase
    end

    // Fetch PC, outstanding count and PC-FIFO pointers; redirect wins over +4
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_pcf_wr      <= '0;
            r_pcf_rd      <= '0;
        end else if (br_taken) begin
            r_fetch_pc    <= br_target;
            r_outstanding <= '0;
            r_pcf_wr      <= '0;
            r_pcf_rd      <= '0;
        end else begin
            if (w_hs)   r_fetch_pc <= r_fetch_pc + PC_W'(4);
            if (w_hs)   r_pcf_wr   <= r_pcf_wr + 1'b1;
            if (w_resp) r_pcf_rd   <= r_pcf_rd + 1'b1;
            r_outstanding <= r_outstanding + c_CW'(w_hs) - c_CW'(w_resp);
        end
    end

    // PC of each accepted request, consumed in order when its data returns
    always_ff @(posedge clk) begin
        if (w_hs) r_pcf[r_pcf_wr] <= r_fetch_pc;
    end

    fetch_queue #(
        .DEPTH (BUF_DEPTH),
        .W     (PC_W)
    ) u_queue (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_pc   (r_pcf[r_pcf_rd]),
        .i_push_inst (w_bus.data),
        .i_pop       (w_pop),
        .i_flush     (br_taken),
        .o_head_pc   (if_to_id_pc),
        .o_head_inst (if_to_id_inst),
        .o_count     (w_q_count),
        .o_empty     (w_q_empty),
        .o_full      (w_q_full)
    );

    a_no_stray_resp: assert property (@(posedge clk) disable iff (reset)
        !(inst_data_ok && (r_outstanding == '0) && (r_cancel == '0)));

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(w_push && w_q_full && !w_pop));

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_if_fetch_unit
// Brief   : Scoreboard bench for if_fetch_unit with an in-order bus model
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_if_fetch_unit;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'hbfc0_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        id_allowin = 1'b0;
    logic        if_to_id_valid;
    logic [31:0] if_to_id_inst;
    logic [31:0] if_to_id_pc;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic [31:0] inst_rdata = '0;

    int total = 0;
    int bad   = 0;
    int addr_ok_pct = 100;
    int data_ok_pct = 100;
    int hs_cnt = 0;
    int deliv_cnt = 0;
    int drops;
    logic [31:0] exp_q[$];
    logic [31:0] bus_q[$];

    if_fetch_unit #(.BUF_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .id_allowin     (id_allowin),
        .if_to_id_valid (if_to_id_valid),
        .if_to_id_inst  (if_to_id_inst),
        .if_to_id_pc    (if_to_id_pc),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_run(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic do_reset(input logic allow);
        tick();
        reset = 1'b1;
        br_taken = 1'b0;
        id_allowin = allow;
        exp_q.delete();
        repeat (2) tick();
        hs_cnt = 0;
        deliv_cnt = 0;
        expect_run(RST_PC, 256);
        reset = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] target);
        exp_q.delete();
        expect_run(target, 256);
    endtask

    // Bus model bookkeeping: record accepted requests, retire delivered responses
    always @(negedge clk) begin
        if (!reset) begin
            if (inst_data_ok && bus_q.size() != 0) bus_q.delete(0);
            if (inst_req && inst_addr_ok) begin
                bus_q.push_back(inst_addr);
                hs_cnt++;
            end
        end
    end

    // Bus model drive: in-order responses, earliest one cycle after acceptance
    always @(posedge clk) begin
        #1;
        inst_addr_ok = ($urandom_range(0, 99) < addr_ok_pct);
        if (reset) begin
            bus_q.delete();
            inst_data_ok = 1'b0;
        end else if (bus_q.size() != 0 && $urandom_range(0, 99) < data_ok_pct) begin
            inst_data_ok = 1'b1;
            inst_rdata   = mem_word(bus_q[0]);
        end else begin
            inst_data_ok = 1'b0;
            inst_rdata   = 32'hdead_beef;
        end
    end

    // Decode-side monitor: every transfer must be the next expected PC
    always @(negedge clk) begin
        if (!reset && if_to_id_valid && id_allowin) begin
            deliv_cnt++;
            if (exp_q.size() == 0) begin
                check("deliver_expected", 32'd0, 32'd1);
            end else begin
                check("deliv_pc", if_to_id_pc, exp_q[0]);
                check("deliv_inst", if_to_id_inst, mem_word(exp_q[0]));
                exp_q.delete(0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) tick();
        @(negedge clk);
        check("rst_req", {31'b0, inst_req}, 32'd0);
        check("rst_valid", {31'b0, if_to_id_valid}, 32'd0);
        check("rst_addr", inst_addr, RST_PC);

        // Zero-wait bus, decode always ready: one per cycle after 2-cycle startup
        do_reset(1'b1);
        @(negedge clk);
        check("first_req", {31'b0, inst_req}, 32'd1);
        check("first_addr", inst_addr, RST_PC);
        repeat (11) @(negedge clk);
        #1;
        check("throughput", 32'(deliv_cnt), 32'd10);

        // Decode stalled: exactly DEPTH requests, head held stable
        do_reset(1'b0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i >= 2) check("stall_hold_pc", if_to_id_pc, RST_PC);
        end
        #1;
        check("stall_hs_cnt", 32'(hs_cnt), 32'(DEPTH));
        check("stall_req_low", {31'b0, inst_req}, 32'd0);
        check("stall_valid", {31'b0, if_to_id_valid}, 32'd1);
        check("stall_inst", if_to_id_inst, mem_word(RST_PC));
        tick();
        id_allowin = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        check("stall_resume_flow", {31'b0, deliv_cnt >= 20}, 32'd1);

        // Redirect with all requests outstanding: every response dropped
        data_ok_pct = 0;
        do_reset(1'b1);
        repeat (8) tick();
        br_target = 32'hbfc0_0100;
        br_taken  = 1'b1;
        @(negedge clk);
        #1;
        check("cancel_inflight", 32'(bus_q.size()), 32'(DEPTH));
        drops = bus_q.size();
        redirect(br_target);
        tick();
        br_taken = 1'b0;
        data_ok_pct = 50;
        for (int i = 0; i < 200 && drops > 0; i++) begin
            @(negedge clk);
            if (i == 0) check("cancel_addr", inst_addr, 32'hbfc0_0100);
            check("cancel_req_low", {31'b0, inst_req}, 32'd0);
            if (inst_data_ok) drops--;
        end
        check("cancel_drained", 32'(drops), 32'd0);
        data_ok_pct = 100;
        deliv_cnt = 0;
        repeat (20) @(negedge clk);
        #1;
        check("cancel_resume_flow", {31'b0, deliv_cnt >= 10}, 32'd1);

        // Redirect in the same cycle as a handshake and a response
        do_reset(1'b1);
        repeat (8) tick();
        br_target = 32'hbfc0_0200;
        br_taken  = 1'b1;
        @(negedge clk);
        check("same_cycle_setup", {31'b0, inst_req && inst_addr_ok && inst_data_ok}, 32'd1);
        #1;
        redirect(br_target);
        tick();
        br_taken = 1'b0;
        @(negedge clk);
        check("same_cycle_addr", inst_addr, 32'hbfc0_0200);
        check("same_cycle_req_low", {31'b0, inst_req}, 32'd0);
        deliv_cnt = 0;
        repeat (20) @(negedge clk);
        #1;
        check("same_cycle_flow", {31'b0, deliv_cnt >= 10}, 32'd1);

        // Pending-but-unaccepted request is abandoned; sequential wrap past ffffffff
        addr_ok_pct = 0;
        do_reset(1'b1);
        repeat (3) tick();
        br_target = 32'hffff_fff8;
        br_taken  = 1'b1;
        @(negedge clk);
        #1;
        redirect(br_target);
        tick();
        br_taken = 1'b0;
        addr_ok_pct = 100;
        @(negedge clk);
        check("pending_req", {31'b0, inst_req}, 32'd1);
        check("pending_addr", inst_addr, 32'hffff_fff8);
        deliv_cnt = 0;
        repeat (20) @(negedge clk);
        #1;
        check("wrap_flow", {31'b0, deliv_cnt >= 10}, 32'd1);

        // Random bus latency and decode back-pressure
        addr_ok_pct = 70;
        data_ok_pct = 60;
        do_reset(1'b1);
        for (int i = 0; i < 150; i++) begin
            tick();
            id_allowin = 1'($urandom_range(0, 1));
        end
        addr_ok_pct = 100;
        data_ok_pct = 100;
        id_allowin  = 1'b1;
        repeat (8) tick();
        check("random_flow", {31'b0, deliv_cnt >= 60}, 32'd1);

        // Asynchronous reset between edges mid-burst
        tick();
        check("pre_rst_req", {31'b0, inst_req}, 32'd1);
        check("pre_rst_valid", {31'b0, if_to_id_valid}, 32'd1);
        #1;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("async_rst_req", {31'b0, inst_req}, 32'd0);
        check("async_rst_valid", {31'b0, if_to_id_valid}, 32'd0);
        repeat (2) tick();
        hs_cnt = 0;
        deliv_cnt = 0;
        expect_run(RST_PC, 256);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_req", {31'b0, inst_req}, 32'd1);
        check("post_rst_addr", inst_addr, RST_PC);
        repeat (15) @(negedge clk);
        #1;
        check("post_rst_flow", {31'b0, deliv_cnt >= 10}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch front end. Sits directly upstream of the decode stage and replaces the bare PC register and synchronous instruction SRAM port.
- Generates sequential PCs and issues requests on a variable-latency sram-like instruction bus (req/addr_ok/data_ok).
- Buffers returned instructions in a small in-order queue and hands them to decode over a valid/allowin handshake.
- Applies branch/jump redirects from decode and cancels any in-flight fetches on the wrong path.

Parameters:
RESET_PC, 32'hbfc00000, first fetch address after reset
BUF_DEPTH, 2, instruction queue entries (power of two, >=2)
PC_W, 32, address/instruction width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
br_taken  in  1  redirect request from decode (single-cycle pulse)
br_target  in  PC_W  redirect address, valid with br_taken
id_allowin  in  1  decode can accept an instruction this cycle
if_to_id_valid  out  1  queue head is valid
if_to_id_inst  out  PC_W  queue head instruction
if_to_id_pc  out  PC_W  queue head PC
inst_req  out  1  bus request
inst_addr  out  PC_W  bus request address
inst_addr_ok  in  1  request accepted this cycle (inst_req && inst_addr_ok = handshake)
inst_data_ok  in  1  one response returned this cycle, in request order
inst_rdata  in  PC_W  response data, valid with inst_data_ok

Behaviour:
- Reset (async, active-high): fetch_pc=RESET_PC; queue empty (head=tail=count=0); outstanding=0; cancel=0; state=RUN; inst_req=0; if_to_id_valid=0. The first inst_req goes high in the first cycle after reset deasserts.
- Credit rule: inst_req = (state==RUN) && (count + outstanding < BUF_DEPTH). A queue slot is reserved for every accepted request, so the queue never overflows.
- inst_addr = fetch_pc, combinational. On handshake: fetch_pc += 4 (mod 2^32, wraps) and outstanding += 1.
- Response in RUN with cancel==0: push {fetch-order PC, inst_rdata} at the tail; outstanding -= 1. Response PCs come from a PC FIFO written at handshake (same depth, same pointers scheme).
- Pop: if_to_id_valid = (count!=0). Head is removed when if_to_id_valid && id_allowin. Outputs hold stable while valid && !allowin.
- Simultaneous push and pop is legal at any count; count stays unchanged.
- Minimum latency is data_ok to if_to_id_valid = 1 cycle. There is no bypass.
- Redirect (br_taken=1), applied at the clock edge:
  - fetch_pc <= br_target. This takes precedence over the +4 from a same-cycle handshake.
  - Queue flushed (count=0). A same-cycle pop is harmless.
  - cancel <= outstanding + (handshake this cycle) - (data_ok this cycle); outstanding <= 0. A data_ok in the redirect cycle is discarded.
  - state <= CANCEL if the new cancel value is nonzero, else RUN.
- Delay slot: decode asserts br_taken only in or after the cycle the delay-slot instruction is popped. This block does not track delay slots.
- State CANCEL:
  - inst_req=0.
  - Each data_ok decrements cancel and its data is dropped.
  - When cancel reaches 0, return to RUN the next cycle.
  - A further br_taken in CANCEL updates fetch_pc only. Outstanding is already 0, so cancel is unchanged.
- A request that is pending but not yet accepted when br_taken arrives carries no commitment. The next cycle inst_addr shows br_target.
- data_ok with outstanding==0 and cancel==0 is a protocol error. Flag it with an assertion; the RTL ignores it.
- Reset mid-operation clears all counters immediately. Any bus responses after reset are the integrator's responsibility: the bus resets on the same reset.

Decomposition:
- Shared cpu package: RESET_PC constant, instruction-width constant, bus request/response struct (addr, data, req, addr_ok, data_ok).
- Sub-module fetch_queue: parametric synchronous FIFO (BUF_DEPTH x {pc,inst}) with push/pop/flush, count, empty/full. Instantiated once.
- Counters and the RUN/CANCEL FSM live in the top.

Test Plan:
- Zero-wait bus (addr_ok=1, data_ok one cycle later), id_allowin=1 -> PCs bfc00000, bfc00004, bfc00008… delivered back-to-back, one per cycle after a 2-cycle startup.
- id_allowin=0 for 10 cycles -> exactly BUF_DEPTH requests issued, then inst_req=0. if_to_id_pc holds bfc00000 stable. On release, fetching resumes with no loss or duplication.
- Two requests outstanding (bfc00010, bfc00014), then br_taken with target bfc00100 -> both responses dropped. inst_req=0 until the second data_ok. Next delivered PC is bfc00100.
- br_taken in the same cycle as a handshake for bfc00020 plus a data_ok -> cancel=outstanding+1-1. The bfc00020 response is dropped and fetch_pc=target.
- fetch_pc=fffffffc sequential -> next request address 00000000.
- Assert reset asynchronously mid-burst (between edges) -> inst_req and if_to_id_valid fall immediately. The first post-reset request is bfc00000.
